// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by bin2bcd_seq and bcd_digit_adjust.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_OFFSET = 4'd3;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX  = 4'd9;

  // Decimal digits of 2^width-1 = floor(width*log10(2)) + 1.
  function automatic int min_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational add-3 correction for one BCD digit, applied before each shift.
// Codes 10-15 never occur in a well-formed working register; they collapse to 0.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    if (digit_i > DIGIT_MAX) begin
      digit_o = '0;
    end else if (digit_i >= ADJ_THRESH) begin
      digit_o = digit_i + ADJ_OFFSET;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, start/done handshake.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and add sign_out.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          ready,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BIN2BCD_SIGNED_EN
  output logic                          sign_out,
`endif
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj_work;
  logic [WIDTH-1:0]   operand;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_d;
  logic sign_out_q, sign_out_d;

  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  assign operand = bin_in[WIDTH-1] ? (-bin_in) : bin_in;
`else
  assign operand = bin_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_i (work_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (adj_work[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    work_d     = work_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_out_d  = bcd_out_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    sign_d     = sign_q;
    sign_out_d = sign_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = operand;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(WIDTH);
`ifdef BIN2BCD_SIGNED_EN
          sign_d    = bin_in[WIDTH-1];
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A carry out of the top digit means the value does not fit; the
        // remaining digits still hold the value modulo 10^DIGITS.
        work_d    = {adj_work[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | adj_work[BCD_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_out_d  = work_q;
        overflow_d = ovf_acc_q;
        done_d     = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
        sign_out_d = sign_q;
`endif
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      work_q     <= '0;
      ovf_acc_q  <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      ovf_acc_q  <= ovf_acc_d;
      bcd_out_q  <= bcd_out_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q     <= sign_d;
      sign_out_q <= sign_out_d;
`endif
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;
`ifdef BIN2BCD_SIGNED_EN
  assign sign_out = sign_out_q;
`endif

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock, so one small digit-correction stage per BCD digit replaces a wide combinational tree of correction cells. It sits between arithmetic results and the seven-segment display driver of the calculator datapath. It adds a start/done handshake, configurable input width and digit count, and overflow detection.

## Interface
- `WIDTH`, 8, binary input width in bits (≥2).
- `DIGITS`, 3, number of BCD output digits (≥1).
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request conversion of `bin_in`; sampled only when `ready`=1.
- `bin_in`  input  WIDTH  binary operand; captured on the accepting edge only.
- `ready`  output  1  high in IDLE; converter can accept `start`.
- `done`  output  1  one-cycle pulse; `bcd_out` and `overflow` are valid from this cycle.
- `bcd_out`  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]. Holds its value until the next `done`.
- `overflow`  output  1  high when the value is ≥ 10^DIGITS. Updates together with `bcd_out`.
- `sign_out`  output  1  present only with `BIN2BCD_SIGNED_EN`; 1 means the input was negative.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE.** `ready`=1.
  - `start`=1: load the shift register with `bin_in` (or its magnitude when signed).
  - Clear the BCD working register and the overflow accumulator.
  - Set bit counter to WIDTH, go to SHIFT.
- **SHIFT.** Each cycle:
  - Adjust every working digit: 0–4 pass unchanged; 5–9 add 3; 10–15 map to 0000 (unreachable in normal operation).
  - Shift {BCD, shift register} left by 1.
  - OR the bit leaving the top digit into the overflow accumulator.
  - Decrement the counter. When the counter reaches 1, go to DONE on the next edge.
- **DONE.** Register the working BCD into `bcd_out` and the accumulator into `overflow`; `done`=1; next state IDLE.
- On overflow, `bcd_out` = value mod 10^DIGITS, exactly.
- `start` while `ready`=0 is ignored; it is not queued.
- `bin_in` changes after capture have no effect.
- `rst`: state IDLE, `ready`=1, `done`=0, `bcd_out`=0, `overflow`=0, `sign_out`=0, counter=0. Reset during SHIFT abandons the conversion and produces no `done`.

## Timing
- `start` sampled at edge E0; SHIFT occupies edges E1..E_WIDTH; `done` is high in the cycle after edge E(WIDTH+1).
- WIDTH=8: `done` follows edge E9.
- `ready` rises in the same cycle as `done`, so a new conversion can start there.
- Throughput: one conversion per WIDTH+2 cycles when `start` is held high.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `BIN2BCD_SIGNED_EN`.
- **Defined.**
  - `bin_in` is two's complement; the magnitude is converted and `sign_out` is registered with `bcd_out`.
  - For -2^(WIDTH-1), the magnitude 2^(WIDTH-1) is converted correctly (unsigned WIDTH-bit magnitude register).
- **Undefined.** `bin_in` is unsigned, the `sign_out` port does not exist, and no negation logic is built.

## Structure
- Package `bin2bcd_pkg` holds:
  - state enum typedef (IDLE/SHIFT/DONE);
  - `BCD_DIGIT_W`=4, `ADJ_THRESH`=5, `ADJ_OFFSET`=3;
  - a function returning the minimum DIGITS for a given WIDTH.
- Sub-module `bcd_digit_adjust`: 4-bit combinational add-3 correction, instantiated DIGITS times via a generate loop.
- FSM, counter and registers live in the top level.

## Test plan
- WIDTH=8, DIGITS=3, `bin_in`=255 → `bcd_out`=0x255, `overflow`=0, `done` exactly 9 edges after the `start` edge.
- `bin_in`=0 and `bin_in`=9 → 0x000 and 0x009; `done` is a single-cycle pulse.
- DIGITS=2, `bin_in`=200 → `bcd_out`=0x00, `overflow`=1; then `bin_in`=99 → 0x99, `overflow`=0.
- Pulse `start` with 123 at E0; `start` with 45 at E3 → only 0x123 reported. `start` held high with 45 → back-to-back results 10 cycles apart.
- Assert `rst` at edge E4 of a conversion → no `done`, all outputs 0, `ready`=1 next cycle. A new conversion of 77 then returns 0x077.
- `BIN2BCD_SIGNED_EN`, WIDTH=8: 8'h80 → `sign_out`=1, `bcd_out`=0x128; 8'hFF → 1, 0x001; 8'h7F → 0, 0x127.
